serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit unsigned adder, the addition counterpart to the team's subtractor cells. Accepts two operands on a start pulse, adds them LSB-first over WIDTH clock cycles using a single 1-bit full-adder cell and a carry flip-flop, then presents the sum and carry-out with a one-cycle done strobe. Intended as the area-cheap arithmetic unit for multi-cycle datapaths where throughput is not critical.

## Interface

- Parameters:
  - WIDTH, 8, operand and sum width in bits (legal range 2–32)
- Ports:
  - clk  input  1  single clock; all state updates on rising edge
  - rst  input  1  reset is synchronous and active-high
  - start  input  1  request to begin an addition; sampled only in IDLE
  - a  input  WIDTH  operand A, captured on accepted start
  - b  input  WIDTH  operand B, captured on accepted start
  - busy  output  1  high while an operation is in progress (SHIFT and DONE)
  - done  output  1  one-cycle strobe: sum/cout valid
  - sum  output  WIDTH  result (a + b) mod 2^WIDTH
  - cout  output  1  carry-out of the MSB

## Operation

- States: IDLE, SHIFT, DONE.
- IDLE: busy=0. If start=1 at a rising edge: load a, b into shift registers, clear the carry FF, clear the bit counter, go to SHIFT.
- SHIFT: each edge computes s = a_sh[0] ^ b_sh[0] ^ c, c_next = majority(a_sh[0], b_sh[0], c). a_sh and b_sh shift right by one. s is inserted at the MSB of the partial-sum register, which shifts right. The counter increments. When the counter reaches WIDTH-1, on that edge also copy the completed partial sum to the sum output and c_next to cout, then go to DONE.
- DONE: done=1 for exactly this cycle; the next edge returns to IDLE unconditionally.
- start is ignored in SHIFT and DONE. No queuing; a dropped request must be re-issued.
- sum and cout change only at completion. They hold their values through IDLE and through the next operation until it completes.
- a and b may change freely after the accepting edge.
- Arithmetic: unsigned. The counter is $clog2(WIDTH) bits wide. No overflow flag beyond cout.

## Timing

- Reset values: busy=0, done=0, sum=0, cout=0, state=IDLE, carry FF=0, counter=0.
- rst has priority over everything. Asserting it mid-SHIFT or in DONE aborts the operation: no done pulse and no result update, and all registers return to their reset values on that edge.
- Latency: start sampled at edge E0. SHIFT occupies the cycles after E0 through E_WIDTH. done is high in the cycle following E_WIDTH, with sum/cout valid from that cycle on.
- busy rises in the cycle after E0 and falls in the cycle after done.
- Throughput: with start held high continuously, a new operation is accepted every WIDTH+2 cycles. The accepting edge is the one that leaves IDLE.
- done and start sampled high in the same cycle: start is ignored, because the state is DONE, not IDLE.

## Structure

- Shared package/header serial_arith_pkg holds:
  - state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2)
  - the default WIDTH constant, for reuse by a future serial subtractor
- Sub-module full_adder_bit: purely combinational, inputs x, y, cin, outputs s, co. It is instantiated once in serial_adder.
- The top level holds the FSM, counter, shift registers, carry FF and result registers.

## Test plan

- Reset then idle: rst high 2 cycles, then start=0 for 20 cycles -> busy=0, done=0, sum=0, cout=0 throughout.
- Basic add (WIDTH=8): a=3, b=5, start 1 cycle -> done exactly 9 edges after acceptance, sum=8, cout=0, busy high for 9 cycles.
- Carry-out cases:
  - a=200, b=100 -> sum=44, cout=1
  - a=255, b=1 -> sum=0, cout=1
  - a=255, b=255 -> sum=254, cout=1
- Start while busy: start a=10, b=20, then pulse start with a=1, b=1 during SHIFT and during DONE -> single done, sum=30. The second request is dropped and sum stays 30 afterwards.
- Reset mid-operation: start a=100, b=100, assert rst at the 4th SHIFT cycle -> no done pulse, sum=0, cout=0, busy=0 on the next cycle. A subsequent a=7, b=9 gives sum=16.
- Back-to-back: hold start=1 with operands changing each accepted edge -> accepts every 10 cycles (WIDTH=8). Each done carries the sum of the operands present at its own accepting edge.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared FSM encodings and default width for the serial arithmetic cells
//   No ports. Exports state_e (IDLE/SHIFT/DONE) and DEFAULT_WIDTH.
package serial_arith_pkg;
   localparam int DEFAULT_WIDTH = 8;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle between a requester and serial_adder
//   start, a, b   : requester -> adder (operands captured on the accepting edge)
//   busy, done    : adder -> requester status, done is a one-cycle strobe
//   sum, cout     : adder -> requester result, updated only at completion
interface serial_adder_if
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   modport master (output start, a, b, input busy, done, sum, cout);
   modport slave  (input start, a, b, output busy, done, sum, cout);
endinterface

// File: rtl/full_adder_bit.sv
// full_adder_bit: combinational 1-bit full adder
//   x, y, cin : addend bits and carry-in
//   s, co     : sum bit and carry-out (majority of the three inputs)
module full_adder_bit (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ cin;
   assign co = (x & y) | (x & cin) | (y & cin);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, one full-adder cell plus a carry flop
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of serial_adder_if (start/a/b in, busy/done/sum/cout out)
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-2:0] ps_q, ps_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_q, c_d, cout_q, cout_d;
   logic             s, co, last;
   logic [WIDTH-1:0] sh;
   full_adder_bit u_fa (.x(a_q[0]), .y(b_q[0]), .cin(c_q), .s(s), .co(co));
   // Partial sum keeps only the WIDTH-1 bits already produced; the bit being
   // computed this cycle completes the word on the final edge.
   assign sh   = {s, ps_q};
   assign last = cnt_q == CNT_W'(WIDTH - 1);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      ps_d    = ps_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         IDLE: if (bus.start) begin
            a_d     = bus.a;
            b_d     = bus.b;
            c_d     = 1'b0;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            c_d   = co;
            ps_d  = sh[WIDTH-1:1];
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
               sum_d   = sh;
               cout_d  = co;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         ps_q    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         ps_q    <= ps_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end
   assign bus.busy = state_q != IDLE;
   assign bus.done = state_q == DONE;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed, table-driven self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;
   localparam int W = 8;
   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[7];
   vec_t b2b[4];
   serial_adder_if #(.WIDTH(W)) bus ();
   serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   task automatic do_add(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] es, input logic ec);
      int n;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = x;
      bus.b = y;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = ~x;
      bus.b = ~y;
      n = 1;
      chk({nm, " busy_after_accept"}, 32'(bus.busy), 32'd1);
      while (!bus.done && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({nm, " latency"}, n, 9);
      chk({nm, " sum"}, 32'(bus.sum), 32'(es));
      chk({nm, " cout"}, 32'(bus.cout), 32'(ec));
      @(negedge clk);
      chk({nm, " done_one_cycle"}, 32'(bus.done), 32'd0);
      chk({nm, " busy_fall"}, 32'(bus.busy), 32'd0);
   endtask
   initial begin
      int ndone, acc, dn, prev_busy, last_acc, t;
      logic [W-1:0] held;
      vecs[0] = '{a: 8'd3,   b: 8'd5,   sum: 8'd8,   cout: 1'b0};
      vecs[1] = '{a: 8'd200, b: 8'd100, sum: 8'd44,  cout: 1'b1};
      vecs[2] = '{a: 8'd255, b: 8'd1,   sum: 8'd0,   cout: 1'b1};
      vecs[3] = '{a: 8'd255, b: 8'd255, sum: 8'd254, cout: 1'b1};
      vecs[4] = '{a: 8'd170, b: 8'd85,  sum: 8'd255, cout: 1'b0};
      vecs[5] = '{a: 8'd128, b: 8'd128, sum: 8'd0,   cout: 1'b1};
      vecs[6] = '{a: 8'd0,   b: 8'd0,   sum: 8'd0,   cout: 1'b0};
      b2b[0]  = '{a: 8'd1,   b: 8'd2,   sum: 8'd3,   cout: 1'b0};
      b2b[1]  = '{a: 8'd250, b: 8'd10,  sum: 8'd4,   cout: 1'b1};
      b2b[2]  = '{a: 8'd77,  b: 8'd88,  sum: 8'd165, cout: 1'b0};
      b2b[3]  = '{a: 8'd128, b: 8'd127, sum: 8'd255, cout: 1'b0};
      rst = 1'b1;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("idle%0d busy/done/sum/cout", i),
             {22'd0, bus.busy, bus.done, bus.sum, bus.cout}, 32'd0);
      end
      for (int i = 0; i < 7; i++)
         do_add($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].cout);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'd10;
      bus.b = 8'd20;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = 8'd0;
      bus.b = 8'd0;
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'd1;
      bus.b = 8'd1;
      @(negedge clk);
      bus.start = 1'b0;
      ndone = 0;
      held = '0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.done) begin
            ndone++;
            held = bus.sum;
            bus.start = 1'b1;
            bus.a = 8'd1;
            bus.b = 8'd1;
         end else bus.start = 1'b0;
      end
      chk("busy_start done_count", ndone, 1);
      chk("busy_start sum_at_done", 32'(held), 32'd30);
      chk("busy_start sum_after", 32'(bus.sum), 32'd30);
      chk("busy_start idle_after", 32'(bus.busy), 32'd0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'd100;
      bus.b = 8'd100;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort done", 32'(bus.done), 32'd0);
      chk("abort sum", 32'(bus.sum), 32'd0);
      chk("abort cout", 32'(bus.cout), 32'd0);
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bus.done || bus.busy) ndone++;
      end
      chk("abort no_activity", ndone, 0);
      do_add("after_abort", 8'd7, 8'd9, 8'd16, 1'b0);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a = b2b[0].a;
      bus.b = b2b[0].b;
      acc = 0;
      dn = 0;
      prev_busy = 0;
      last_acc = -1;
      t = 0;
      while (dn < 4 && t < 80) begin
         @(negedge clk);
         t++;
         if (bus.busy && prev_busy == 0) begin
            if (last_acc >= 0) chk($sformatf("b2b interval%0d", acc), t - last_acc, 10);
            last_acc = t;
            acc++;
            if (acc < 4) begin
               bus.a = b2b[acc].a;
               bus.b = b2b[acc].b;
            end else bus.start = 1'b0;
         end
         if (bus.done) begin
            chk($sformatf("b2b sum%0d", dn), 32'(bus.sum), 32'(b2b[dn].sum));
            chk($sformatf("b2b cout%0d", dn), 32'(bus.cout), 32'(b2b[dn].cout));
            dn++;
         end
         prev_busy = int'(bus.busy);
      end
      chk("b2b done_count", dn, 4);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      chk("b2b final_idle", 32'(bus.busy), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
